// File: rtl/frame_ram_pkg.sv
// frame_ram_pkg: shared widths and FSM state type for the frame RAM arbiter
package frame_ram_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;
    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;
endpackage

// File: rtl/frame_ram_arbiter.sv
// frame_ram_arbiter: shares one single-port frame RAM between a camera writer and a UART reader
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(RD_LAT + 1);

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] lat_cnt;
    logic          wr_elig;
    logic          rd_elig;
    logic          starved;
    logic          wr_grant;
    logic          rd_grant;

    // Requests are ignored while their own handshake is high; the cycle after a
    // write grant is a recovery slot in which nothing is granted, so a held write
    // runs at one per two clocks and a pending read only wins once starved.
    always_comb begin
        wr_elig  = wr_req && !wr_ack;
        rd_elig  = rd_req && !rd_valid;
        starved  = rd_elig && (starve_cnt == SW'(STARVE_MAX));
        wr_grant = (state == IDLE) && wr_elig && !starved;
        rd_grant = (state == IDLE) && !wr_ack && rd_elig && !wr_grant;
    end

    // Count writes granted over a pending read; cleared by a read grant or when no read is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (!rd_req || rd_grant)
            starve_cnt <= '0;
        else if (wr_grant && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + SW'(1);
    end

    // Grant FSM with registered RAM controls and handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            wr_ack   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_ack   <= 1'b0;
            rd_valid <= 1'b0;
            ram_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_grant) begin
                        ram_addr <= wr_addr;
                        ram_data <= wr_data;
                        ram_wren <= 1'b1;
                        wr_ack   <= 1'b1;
                    end else if (rd_grant) begin
                        ram_addr <= rd_addr;
                        lat_cnt  <= CW'(RD_LAT);
                        busy     <= 1'b1;
                        state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        rd_data  <= ram_q;
                        rd_valid <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb_frame_ram_arbiter: directed stimulus against a transaction-level model and an external RAM model
module tb_frame_ram_arbiter;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int RD_LAT = 1;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic          busy;

    int n_chk = 0;
    int n_pass = 0;

    frame_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External single-port RAM: write on wren, read data RD_LAT edges after address sample.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] q_pipe [0:RD_LAT-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        for (int i = 0; i < RD_LAT; i++) q_pipe[i] = '0;
    end
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        q_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ram_q = q_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: per edge decide write grant, read grant or idle, and track read completion time.
    logic          e_ack, e_val, e_wren, e_busy;
    logic [AW-1:0] e_addr, m_raddr;
    logic [DW-1:0] e_data, e_rdata;
    logic [DW-1:0] shadow [int];
    int            m_starve, m_left;
    logic          ack_prev, val_prev, r_ok;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_ack = 0; e_val = 0; e_wren = 0; e_busy = 0;
            e_addr = '0; e_data = '0; e_rdata = '0;
            m_starve = 0; m_left = 0;
        end else begin
            ack_prev = e_ack;
            val_prev = e_val;
            e_ack = 0; e_val = 0; e_wren = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_val = 1;
                    e_busy = 0;
                    e_rdata = shadow.exists(int'(m_raddr)) ? shadow[int'(m_raddr)] : '0;
                end
            end else if (!ack_prev) begin
                r_ok = rd_req && !val_prev;
                if (wr_req && !(r_ok && m_starve == STARVE_MAX)) begin
                    e_ack = 1; e_wren = 1; e_addr = wr_addr; e_data = wr_data;
                    shadow[int'(wr_addr)] = wr_data;
                    if (rd_req && m_starve < STARVE_MAX) m_starve++;
                end else if (r_ok) begin
                    e_addr = rd_addr; e_busy = 1; m_raddr = rd_addr;
                    m_left = RD_LAT + 1; m_starve = 0;
                end
            end
            if (!rd_req) m_starve = 0;
        end
    end

    // Compare every DUT output against the model shortly after each edge.
    always @(posedge clk) begin
        #1;
        chk("m_wr_ack", wr_ack, e_ack);
        chk("m_rd_valid", rd_valid, e_val);
        chk("m_ram_wren", ram_wren, e_wren);
        chk("m_busy", busy, e_busy);
        chk("m_ram_addr", ram_addr, e_addr);
        chk("m_ram_data", ram_data, e_data);
        chk("m_rd_data", rd_data, e_rdata);
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); wr_req = 1; wr_addr = a; wr_data = d;
        @(posedge clk); #2;
        chk("wr_ack", wr_ack, 1); chk("wr_wren", ram_wren, 1);
        chk("wr_addr", ram_addr, a); chk("wr_data", ram_data, d);
        @(negedge clk); wr_req = 0;
        @(posedge clk); #2;
        chk("wr_ack_one_cycle", wr_ack, 0); chk("wr_wren_drop", ram_wren, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); rd_req = 1; rd_addr = a;
        @(posedge clk); #2;
        chk("rd_grant_busy", busy, 1); chk("rd_grant_addr", ram_addr, a);
        chk("rd_grant_wren", ram_wren, 0); chk("rd_grant_valid", rd_valid, 0);
        @(negedge clk); rd_req = 0;
        repeat (RD_LAT) begin
            @(posedge clk); #2;
            chk("rd_wait_valid", rd_valid, 0); chk("rd_wait_busy", busy, 1);
            chk("rd_wait_addr_hold", ram_addr, a);
        end
        @(posedge clk); #2;
        chk("rd_valid", rd_valid, 1); chk("rd_data", rd_data, d); chk("rd_done_busy", busy, 0);
        @(posedge clk); #2;
        chk("rd_valid_one_cycle", rd_valid, 0); chk("rd_data_hold", rd_data, d);
    endtask

    int  acks, dbl, resumed, late_val;
    bit  prev_ack, busy_seen, got;

    initial begin
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        chk("rst_wren", ram_wren, 0); chk("rst_busy", busy, 0); chk("rst_addr", ram_addr, 0);
        // first grant on the first edge after release
        @(negedge clk); rst = 0; wr_req = 1; wr_addr = 15'h0010; wr_data = 8'hA5;
        @(posedge clk); #2;
        chk("first_wr_ack", wr_ack, 1); chk("first_wr_wren", ram_wren, 1);
        chk("first_wr_addr", ram_addr, 15'h0010); chk("first_wr_data", ram_data, 8'hA5);
        @(negedge clk); wr_req = 0;
        @(posedge clk); #2;
        chk("first_wr_ack_drop", wr_ack, 0); chk("first_wr_wren_drop", ram_wren, 0);
        do_read(15'h0010, 8'hA5);
        do_write(15'h0010, 8'h3C);
        do_read(15'h0010, 8'h3C);

        // simultaneous held requests: write first, four writes, then the read
        @(negedge clk); wr_req = 1; wr_addr = 15'h0200; wr_data = 8'h11; rd_req = 1; rd_addr = 15'h0300;
        acks = 0; dbl = 0; prev_ack = 0; busy_seen = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #2;
            if (i == 0) chk("sim_first_is_write", wr_ack, 1);
            if (wr_ack && prev_ack) dbl++;
            prev_ack = wr_ack;
            if (busy) busy_seen = 1;
            if (wr_ack && !busy_seen) acks++;
            if (rd_valid) got = 1;
        end
        chk("starve_read_done", got, 1);
        chk("starve_write_count", acks, 4);
        chk("no_double_ack", dbl, 0);
        chk("starve_rd_data", rd_data, 8'h00);
        @(negedge clk); rd_req = 0;
        resumed = 0;
        repeat (3) begin @(posedge clk); #2; if (wr_ack) resumed++; end
        chk("writes_resume", resumed > 0, 1);
        @(negedge clk); wr_req = 0;
        repeat (3) @(posedge clk);

        // reset while waiting for read data
        @(negedge clk); rd_req = 1; rd_addr = 15'h0010;
        @(posedge clk); #2; chk("rst_case_busy", busy, 1);
        @(negedge clk); rd_req = 0;
        #2 rst = 1;
        #1;
        chk("arst_busy", busy, 0); chk("arst_valid", rd_valid, 0); chk("arst_ack", wr_ack, 0);
        chk("arst_wren", ram_wren, 0); chk("arst_addr", ram_addr, 0);
        chk("arst_data", ram_data, 0); chk("arst_rd_data", rd_data, 0);
        @(negedge clk); rst = 0;
        late_val = 0;
        repeat (6) begin @(posedge clk); #2; if (rd_valid) late_val++; end
        chk("aborted_read_silent", late_val, 0);
        do_read(15'h0010, 8'h3C);

        // address extremes
        do_write(15'h7FFF, 8'hFF);
        do_read(15'h7FFF, 8'hFF);
        do_read(15'h0000, 8'h00);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 15, frame RAM address width.
REQ-002 Parameter DATA_W, 8, frame RAM data width.
REQ-003 Parameter RD_LAT, 1, RAM clock edges from address sample to valid q (1..3).
REQ-004 Parameter STARVE_MAX, 4, consecutive write grants allowed while rd_req is pending.
REQ-005 Port: clk  in  1  single system clock; all logic is on its rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Ports: wr_req in 1, wr_addr in ADDR_W, wr_data in DATA_W, wr_ack out 1; camera write requester.
REQ-008 Ports: rd_req in 1, rd_addr in ADDR_W, rd_data out DATA_W, rd_valid out 1; UART host read requester.
REQ-009 Ports: ram_addr out ADDR_W, ram_data out DATA_W, ram_wren out 1, ram_q in DATA_W; single-port frame RAM.
REQ-010 Port: busy  out  1  high while a read is in flight (any state other than IDLE).

Function
REQ-011 All outputs SHALL be registered.
REQ-012 FSM states SHALL be IDLE and RD_WAIT only.
REQ-013 Eligibility: wr_req SHALL be ignored in any cycle where wr_ack is high; rd_req SHALL be ignored in any cycle where rd_valid is high.
REQ-014 Grants SHALL be made only in IDLE.
REQ-015 Write priority: the eligible write SHALL win, unless rd_req is eligible and starve_cnt==STARVE_MAX, in which case the read SHALL win.
REQ-016 Write grant at edge E: ram_addr<=wr_addr, ram_data<=wr_data, ram_wren<=1, wr_ack<=1 for exactly one cycle; state stays IDLE.
REQ-017 Max write throughput SHALL be one per 2 clk for a held request.
REQ-018 Write grant with rd_req pending SHALL increment starve_cnt, saturating at STARVE_MAX.
REQ-019 Any read grant SHALL clear starve_cnt to 0; starve_cnt SHALL also be 0 whenever rd_req is low.
REQ-020 Read grant at edge E: ram_addr<=rd_addr, ram_wren<=0, state<=RD_WAIT, down-counter<=RD_LAT.
REQ-021 At edge E+RD_LAT+1: rd_data<=ram_q, rd_valid<=1 for exactly one cycle, state<=IDLE.
REQ-022 rd_data SHALL hold its value until the next read completes.
REQ-023 In RD_WAIT, wr_req SHALL stall (wr_ack low) and ram_addr SHALL be held stable.
REQ-024 ram_wren SHALL return to 0 on the edge after any write unless a new write is granted.
REQ-025 Simultaneous eligible wr_req and rd_req with starve_cnt<STARVE_MAX SHALL grant the write.
REQ-026 ram_addr and ram_data SHALL wrap nowhere; addresses pass through unmodified, full ADDR_W width.

Reset
REQ-027 rst SHALL immediately force: state=IDLE, ram_wren=0, wr_ack=0, rd_valid=0, busy=0, ram_addr=0, ram_data=0, rd_data=0, starve_cnt=0.
REQ-028 Reset during RD_WAIT SHALL abort the read; no rd_valid SHALL follow for it after release.
REQ-029 The first grant SHALL be possible at the first clk edge after rst deasserts.

Structure
REQ-030 Shared package frame_ram_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state type.
REQ-031 The block SHALL be a single module with no sub-modules; the RAM stays external.

Verification
REQ-032 Single write: wr_req=1, wr_addr=0x0010, wr_data=0xA5 -> ram_wren=1 and wr_ack=1 for one cycle at E+1; readback at 0x0010 returns 0xA5.
REQ-033 Single read with RD_LAT=1 from addr 0x0010 preloaded with 0x3C -> rd_valid one cycle, 2 edges after grant, rd_data=0x3C; busy high in between.
REQ-034 Starvation: wr_req held continuously and rd_req asserted -> exactly 4 writes are granted, then the read; rd_valid follows and writes resume.
REQ-035 Simultaneous first-cycle wr_req and rd_req -> write granted first; with requests held, no double ack on consecutive cycles.
REQ-036 rst pulse in RD_WAIT -> all outputs 0 immediately; no rd_valid after release; a new read afterwards completes normally.
REQ-037 Boundary address 0x7FFF write 0xFF then read -> rd_data=0xFF; address 0x0000 is unaffected.
